// File: rtl/clock_pkg.sv
// Shared definitions for the clock datapath: converter FSM encoding, time
// limits, double-dabble iteration count and 7-segment code constants.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [4:0] HOURS_MAX   = 5'd23;
    localparam logic [5:0] MINUTES_MAX = 6'd59;
    localparam logic [2:0] ITER_COUNT  = 3'd6;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Double-dabble correction: a nibble of 5 or more would overflow the
    // decimal digit once doubled, so pre-add 3.
    function automatic logic [3:0] bcd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment pattern; values 10..15 are blank.
module seg7_decode
    import clock_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Digit lookup; anything outside 0..9 shows nothing.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_digit_encoder.sv
// Binary hours/minutes to four decimal digit fields using a 6-iteration
// sequential double-dabble with request/busy/done handshake.
// Optional 4-digit 7-segment scan, built when TIME_DIGIT_SEG_SCAN_EN is
// defined; otherwise o_seg and o_an are tied low.
module time_digit_encoder
    import clock_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] i_hours,
    input  logic [5:0] i_minutes,
    input  logic       i_valid,
    output logic [1:0] o_hours_left,
    output logic [3:0] o_hours_right,
    output logic [2:0] o_minutes_left,
    output logic [3:0] o_minutes_right,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [6:0] o_seg,
    output logic [3:0] o_an
);

    if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_scan_div_check
        $error("time_digit_encoder: SCAN_DIV must be within 2..65535");
    end

    state_e     state_q, state_d;
    logic [5:0] hbin_q, hbin_d;
    logic [5:0] mbin_q, mbin_d;
    // Tens scratch is sized to the largest reachable tens digit (3 for
    // hours, 6 for minutes); with no hundreds place, a tens field of 5+
    // before a shift is unreachable, so it never needs correction.
    logic [1:0] ht_q, ht_d;
    logic [3:0] hu_q, hu_d;
    logic [2:0] mt_q, mt_d;
    logic [3:0] mu_q, mu_d;
    logic [2:0] cnt_q, cnt_d;
    logic       err_pend_q, err_pend_d;
    logic [1:0] hours_left_q, hours_left_d;
    logic [3:0] hours_right_q, hours_right_d;
    logic [2:0] minutes_left_q, minutes_left_d;
    logic [3:0] minutes_right_q, minutes_right_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [3:0] hu_adj;
    logic [3:0] mu_adj;

    // Converter state and result registers; reset aborts any conversion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            hbin_q          <= '0;
            mbin_q          <= '0;
            ht_q            <= '0;
            hu_q            <= '0;
            mt_q            <= '0;
            mu_q            <= '0;
            cnt_q           <= '0;
            err_pend_q      <= 1'b0;
            hours_left_q    <= '0;
            hours_right_q   <= '0;
            minutes_left_q  <= '0;
            minutes_right_q <= '0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            hbin_q          <= hbin_d;
            mbin_q          <= mbin_d;
            ht_q            <= ht_d;
            hu_q            <= hu_d;
            mt_q            <= mt_d;
            mu_q            <= mu_d;
            cnt_q           <= cnt_d;
            err_pend_q      <= err_pend_d;
            hours_left_q    <= hours_left_d;
            hours_right_q   <= hours_right_d;
            minutes_left_q  <= minutes_left_d;
            minutes_right_q <= minutes_right_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

    // Next-state: capture in IDLE, adjust-and-shift in SHIFT, publish in DONE.
    always_comb begin
        state_d         = state_q;
        hbin_d          = hbin_q;
        mbin_d          = mbin_q;
        ht_d            = ht_q;
        hu_d            = hu_q;
        mt_d            = mt_q;
        mu_d            = mu_q;
        cnt_d           = cnt_q;
        err_pend_d      = err_pend_q;
        hours_left_d    = hours_left_q;
        hours_right_d   = hours_right_q;
        minutes_left_d  = minutes_left_q;
        minutes_right_d = minutes_right_q;
        done_d          = 1'b0;
        err_d           = err_q;
        hu_adj          = bcd_adj(hu_q);
        mu_adj          = bcd_adj(mu_q);

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    hbin_d     = {1'b0, i_hours};
                    mbin_d     = i_minutes;
                    ht_d       = '0;
                    hu_d       = '0;
                    mt_d       = '0;
                    mu_d       = '0;
                    cnt_d      = '0;
                    err_pend_d = (i_hours > HOURS_MAX) || (i_minutes > MINUTES_MAX);
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ht_d   = {ht_q[0], hu_adj[3]};
                hu_d   = {hu_adj[2:0], hbin_q[5]};
                hbin_d = {hbin_q[4:0], 1'b0};
                mt_d   = {mt_q[1:0], mu_adj[3]};
                mu_d   = {mu_adj[2:0], mbin_q[5]};
                mbin_d = {mbin_q[4:0], 1'b0};
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == ITER_COUNT - 3'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                hours_left_d    = ht_q;
                hours_right_d   = hu_q;
                minutes_left_d  = mt_q;
                minutes_right_d = mu_q;
                done_d          = 1'b1;
                err_d           = err_pend_q;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_hours_left    = hours_left_q;
    assign o_hours_right   = hours_right_q;
    assign o_minutes_left  = minutes_left_q;
    assign o_minutes_right = minutes_right_q;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_done          = done_q;
    assign o_err           = err_q;

`ifdef TIME_DIGIT_SEG_SCAN_EN
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  scan_digit;

    // Free-running scan prescaler and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Advance the digit index each time the prescaler wraps.
    always_comb begin
        presc_d = presc_q + 16'd1;
        idx_d   = idx_q;
        if (presc_q == SCAN_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
    end

    // Select the registered digit for the lit position (0 = minutes units).
    always_comb begin
        scan_digit = minutes_right_q;
        case (idx_q)
            2'd0: scan_digit = minutes_right_q;
            2'd1: scan_digit = {1'b0, minutes_left_q};
            2'd2: scan_digit = hours_right_q;
            2'd3: scan_digit = {2'b00, hours_left_q};
            default: scan_digit = minutes_right_q;
        endcase
    end

    seg7_decode u_seg7_decode (
        .i_digit (scan_digit),
        .o_seg   (o_seg)
    );

    assign o_an = 4'b0001 << idx_q;
`else
    assign o_seg = SEG_BLANK;
    assign o_an  = 4'h0;
`endif

endmodule

// File: doc/time_digit_encoder.md
# time_digit_encoder

Converts the binary time held by the timekeeping counter (5-bit hours, 6-bit minutes) back into the four decimal digit fields used by the clock's set/entry path (hours tens/units, minutes tens/units). It is the inverse of the digit-to-binary load path. It uses a multi-cycle sequential double-dabble converter with a request/busy/done handshake. Optionally, it also time-multiplexes the digits onto a 4-digit 7-segment display.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles each display digit stays lit; legal range 2..65535.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_hours  in  5  binary hours, nominally 0..23.
- i_minutes  in  6  binary minutes, nominally 0..59.
- i_valid  in  1  conversion request; sampled only in IDLE.
- o_hours_left  out  2  hours tens digit.
- o_hours_right  out  4  hours units digit.
- o_minutes_left  out  3  minutes tens digit.
- o_minutes_right  out  4  minutes units digit.
- o_busy  out  1  high while a conversion is in progress.
- o_done  out  1  one-cycle pulse when the digit outputs update.
- o_err  out  1  latched with each o_done: high if i_hours>23 or i_minutes>59 at capture.
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- o_an  out  4  digit enable, one-hot, active-high; bit 0 = minutes units, bit 3 = hours tens.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - When i_valid=1, capture i_hours and i_minutes into shift registers, clear the BCD scratch registers, set the bit counter to 0, and go to SHIFT.
  - Compute o_err for the pending result at the same time.
- SHIFT:
  - Each cycle, add 3 to every scratch BCD nibble that is ≥5, then shift left by one, bringing in the next MSB of the binary value.
  - Run hours and minutes in parallel. Hours are zero-extended to 6 bits so both finish in exactly 6 iterations.
  - After iteration 6, go to DONE.
- DONE:
  - Register the scratch nibbles onto the four digit outputs (truncated to the port widths; the maximum inputs 31→3,1 and 63→6,3 fit without loss).
  - Pulse o_done, update o_err, and return to IDLE.
- i_valid is ignored while in SHIFT or DONE. No request is queued.
- Out-of-range inputs are still converted faithfully; only o_err flags them.
- Display scan (when compiled in):
  - A prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - o_an = 1<<index.
  - o_seg = 7-segment code of the selected *registered* digit. Codes for 0–9 are standard; codes 10–15 display blank (7'h00).
  - The scan runs continuously and independently of the FSM. A digit update takes effect on the next scan cycle after o_done.

## Timing
- Request latency:
  - i_valid is high in IDLE at cycle N.
  - o_busy is high in cycles N+1..N+7.
  - The digit outputs, o_done and o_err change at the edge ending cycle N+7, i.e. they are visible in cycle N+8.
  - o_done is high for cycle N+8 only.
  - The next request can be accepted in cycle N+8.
- Back-to-back: i_valid held high gives one conversion every 8 cycles.
- Reset values: all digit outputs 0, o_busy 0, o_done 0, o_err 0, FSM IDLE, prescaler 0, index 0, o_an 4'b0001, o_seg 7'b0111111 ("0").
- Reset asserted mid-conversion aborts immediately. On release, the block is in IDLE with all outputs at their reset values. A partial result is never presented.
- The digit outputs hold their value between conversions.

## Configuration
- Macro TIME_DIGIT_SEG_SCAN_EN.
- Defined: the prescaler, the scan index and the 7-segment decode are built, and behave as described above.
- Undefined:
  - None of that logic is built.
  - o_seg is tied to 7'h00 and o_an to 4'h0. The ports remain so that the interface is identical in both builds.
  - SCAN_DIV is unused.
- The converter, handshake and o_err are identical in both builds.

## Structure
- Shared package clock_pkg:
  - FSM state encoding.
  - HOURS_MAX=23, MINUTES_MAX=59.
  - ITER_COUNT=6.
  - The 7-segment code constants for 0–9 and blank.
- One sub-module, seg7_decode: 4-bit digit in, 7-bit segment pattern out, combinational. It is instantiated once, after the scan mux.

## Test plan
- Reset, then i_valid with hours=0, minutes=0 → after 8 cycles, digits 0,0,0,0; o_done for one cycle; o_err=0.
- hours=23, minutes=59 → digits 2,3,5,9 exactly at N+8; o_busy high N+1..N+7; o_err=0.
- hours=31, minutes=63 → digits 3,1,6,3, o_err=1. Then hours=12, minutes=7 → digits 1,2,0,7, o_err=0.
- i_valid held high with the inputs changing every cycle → conversions start at N, N+8, N+16; each result matches the inputs sampled at its own start cycle.
- rst pulsed low at cycle N+3 of a conversion of 19:45 → all outputs return to reset values; o_done never pulses for that conversion.
- With TIME_DIGIT_SEG_SCAN_EN defined, SCAN_DIV=4, digits 1,2,3,4 → o_an steps 0001→0010→0100→1000 every 4 cycles, with o_seg codes for 4,3,2,1 respectively. With the macro undefined → o_seg=0 and o_an=0 throughout.
